// File: rtl/rv32_exec_unit_pkg.sv
// Shared RV32I execute-stage definitions: major opcodes and funct3 codes.
// No logic; constants only.
// Imported by the execute unit and its immediate generator.
package rv32_exec_unit_pkg;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // ALU funct3 codes
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Branch funct3 codes
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/rv32_imm_gen.sv
// Immediate generator: extracts and sign-extends the I/S/B/U/J immediate from instr.
// Latency: combinational.
// No flow control; unknown opcodes yield zero.
module rv32_imm_gen
    import rv32_exec_unit_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    // Select the immediate layout from the major opcode
    always_comb begin
        imm = 32'b0;
        case (instr[6:0])
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM:
                imm = {{21{instr[31]}}, instr[30:20]};
            OP_STORE:
                imm = {{21{instr[31]}}, instr[30:25], instr[11:7]};
            OP_BRANCH:
                imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {instr[31:12], 12'b0};
            OP_JAL:
                imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = 32'b0;
        endcase
    end

endmodule

// File: rtl/rv32_exec_unit.sv
// RV32I execute stage: ALU, branch comparator and immediate decode.
// Latency: 0 cycles (REG_OUT=0) or 1 cycle (REG_OUT=1).
// No backpressure; the pipeline advances every cycle.
module rv32_exec_unit
    import rv32_exec_unit_pkg::*;
#(
    parameter bit REG_OUT = 1'b0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] instr,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] result,
    output logic        take_b,
    output logic [31:0] imm
);

    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7b5;
    logic [4:0]  shamt;
    logic [32:0] diff;
    logic        eq;
    logic        lt_u;
    logic        lt_s;
    logic        is_alu;
    logic [31:0] result_c;
    logic        take_c;
    logic [31:0] imm_c;

    assign op    = instr[6:0];
    assign f3    = instr[14:12];
    assign f7b5  = instr[30];
    assign shamt = in_b[4:0];

    // One subtractor shared by SUB, SLT/SLTU and every branch compare.
    // diff[32] is the borrow, i.e. unsigned a < b.
    assign diff = {1'b0, in_a} - {1'b0, in_b};
    assign eq   = (diff[31:0] == 32'b0);
    assign lt_u = diff[32];
    // With differing signs the negative operand is smaller; otherwise the
    // difference cannot overflow and its sign bit gives the answer.
    assign lt_s = (in_a[31] != in_b[31]) ? in_a[31] : diff[31];

    assign is_alu = (op == OP_R) || (op == OP_IMM);

    // ALU result; non-ALU opcodes use the adder for address/link/PC math
    always_comb begin
        result_c = in_a + in_b;
        if (is_alu) begin
            case (f3)
                F3_ADD:  result_c = (op == OP_R && f7b5) ? diff[31:0] : (in_a + in_b);
                F3_SLL:  result_c = in_a << shamt;
                F3_SLT:  result_c = {31'b0, lt_s};
                F3_SLTU: result_c = {31'b0, lt_u};
                F3_XOR:  result_c = in_a ^ in_b;
                F3_SR:   result_c = f7b5 ? 32'($signed(in_a) >>> shamt) : (in_a >> shamt);
                F3_OR:   result_c = in_a | in_b;
                F3_AND:  result_c = in_a & in_b;
                default: result_c = in_a + in_b;
            endcase
        end
    end

    // Branch condition, only meaningful for the branch opcode
    always_comb begin
        take_c = 1'b0;
        if (op == OP_BRANCH) begin
            case (f3)
                F3_BEQ:  take_c = eq;
                F3_BNE:  take_c = !eq;
                F3_BLT:  take_c = lt_s;
                F3_BGE:  take_c = !lt_s;
                F3_BLTU: take_c = lt_u;
                F3_BGEU: take_c = !lt_u;
                default: take_c = 1'b0;
            endcase
        end
    end

    rv32_imm_gen u_imm_gen (
        .instr (instr),
        .imm   (imm_c)
    );

    generate
        if (REG_OUT) begin : g_reg
            // Output register; reset wins over whatever is on the inputs
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    result <= 32'b0;
                    take_b <= 1'b0;
                    imm    <= 32'b0;
                end else begin
                    result <= result_c;
                    take_b <= take_c;
                    imm    <= imm_c;
                end
            end
        end else begin : g_comb
            // Clock and reset are not needed when outputs are combinational
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ resetn;
            assign result = result_c;
            assign take_b = take_c;
            assign imm    = imm_c;
        end
    endgenerate

endmodule

// File: tb/tb_rv32_exec_unit.sv
// Directed-vector bench for rv32_exec_unit, combinational and registered builds.
// Latency: checks same-cycle (REG_OUT=0) and one-cycle (REG_OUT=1) behaviour.
// No flow control in the design; inputs are driven every cycle.
module tb_rv32_exec_unit;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_result;
        logic        exp_take;
        logic [31:0] exp_imm;
    } vec_t;

    localparam int NV = 29;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] instr, in_a, in_b;
    logic [31:0] result0, imm0, result1, imm1;
    logic        take0, take1;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vt [NV];

    always #5 clk = ~clk;

    rv32_exec_unit #(.REG_OUT(1'b0)) dut_comb (
        .clk (clk), .resetn (resetn), .instr (instr), .in_a (in_a), .in_b (in_b),
        .result (result0), .take_b (take0), .imm (imm0)
    );

    rv32_exec_unit #(.REG_OUT(1'b1)) dut_reg (
        .clk (clk), .resetn (resetn), .instr (instr), .in_a (in_a), .in_b (in_b),
        .result (result1), .take_b (take1), .imm (imm1)
    );

    task automatic check(input string what, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec%0d: got %08h expected %08h", what, idx, act, exp);
        end
    endtask

    task automatic check_comb(input int idx);
        check("comb.result", idx, result0, vt[idx].exp_result);
        check("comb.take_b", idx, {31'b0, take0}, {31'b0, vt[idx].exp_take});
        check("comb.imm", idx, imm0, vt[idx].exp_imm);
    endtask

    task automatic check_reg(input int idx);
        check("reg.result", idx, result1, vt[idx].exp_result);
        check("reg.take_b", idx, {31'b0, take1}, {31'b0, vt[idx].exp_take});
        check("reg.imm", idx, imm1, vt[idx].exp_imm);
    endtask

    task automatic check_reg_zero(input string what);
        check({what, ".result"}, -1, result1, 32'h0);
        check({what, ".take_b"}, -1, {31'b0, take1}, 32'h0);
        check({what, ".imm"}, -1, imm1, 32'h0);
    endtask

    task automatic apply(input int idx);
        instr = vt[idx].instr;
        in_a  = vt[idx].a;
        in_b  = vt[idx].b;
    endtask

    initial begin
        //        instr          a             b             result        take  imm
        vt[0]  = '{32'h40208033, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 32'h00000000}; // SUB
        vt[1]  = '{32'h00208033, 32'h00000005, 32'h00000007, 32'h0000000C, 1'b0, 32'h00000000}; // ADD
        vt[2]  = '{32'h40315093, 32'h80000000, 32'h00000403, 32'hF0000000, 1'b0, 32'h00000403}; // SRAI 3
        vt[3]  = '{32'h00315093, 32'h80000000, 32'h00000003, 32'h10000000, 1'b0, 32'h00000003}; // SRLI 3
        vt[4]  = '{32'h0020A033, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 32'h00000000}; // SLT
        vt[5]  = '{32'h0020B033, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 32'h00000000}; // SLTU
        vt[6]  = '{32'hFE004FE3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 32'hFFFFFFFE}; // BLT
        vt[7]  = '{32'hFE006FE3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 32'hFFFFFFFE}; // BLTU
        vt[8]  = '{32'hFE000FE3, 32'h00000003, 32'h00000003, 32'h00000006, 1'b1, 32'hFFFFFFFE}; // BEQ
        vt[9]  = '{32'hFE002FE3, 32'h00000003, 32'h00000003, 32'h00000006, 1'b0, 32'hFFFFFFFE}; // f3=010
        vt[10] = '{32'hFE001FE3, 32'h00000003, 32'h00000003, 32'h00000006, 1'b0, 32'hFFFFFFFE}; // BNE
        vt[11] = '{32'hFE005FE3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 32'hFFFFFFFE}; // BGE
        vt[12] = '{32'hFE007FE3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 32'hFFFFFFFE}; // BGEU
        vt[13] = '{32'hFE20AE23, 32'h00000100, 32'hFFFFFFFC, 32'h000000FC, 1'b0, 32'hFFFFFFFC}; // SW -4
        vt[14] = '{32'h123450B7, 32'h00000000, 32'h12345000, 32'h12345000, 1'b0, 32'h12345000}; // LUI
        vt[15] = '{32'h001000EF, 32'h00000100, 32'h00000004, 32'h00000104, 1'b0, 32'h00000800}; // JAL
        vt[16] = '{32'h0000007F, 32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 32'h00000000}; // unknown
        vt[17] = '{32'h12345097, 32'h00001000, 32'h12345000, 32'h12346000, 1'b0, 32'h12345000}; // AUIPC
        vt[18] = '{32'h40008093, 32'h0000000A, 32'h00000400, 32'h0000040A, 1'b0, 32'h00000400}; // ADDI, bit30 set
        vt[19] = '{32'h0020C033, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 32'h00000000}; // XOR
        vt[20] = '{32'h0020E033, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 32'h00000000}; // OR
        vt[21] = '{32'h0020F033, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 32'h00000000}; // AND
        vt[22] = '{32'h00209033, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 1'b0, 32'h00000000}; // SLL 31
        vt[23] = '{32'h4020D033, 32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 32'h00000000}; // SRA 4
        vt[24] = '{32'h00C08067, 32'h00000200, 32'h0000000C, 32'h0000020C, 1'b0, 32'h0000000C}; // JALR
        vt[25] = '{32'hFFC0A083, 32'h00000100, 32'hFFFFFFFC, 32'h000000FC, 1'b0, 32'hFFFFFFFC}; // LW -4
        vt[26] = '{32'h40208033, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 32'h00000000}; // SUB wrap
        vt[27] = '{32'h0020A033, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 32'h00000000}; // SLT max vs min
        vt[28] = '{32'hFE004FE3, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE}; // BLT min<max

        // Reset holds the registered outputs at zero regardless of inputs
        resetn = 1'b0;
        apply(15);
        repeat (2) @(posedge clk);
        #1;
        check_reg_zero("reset");
        @(negedge clk);
        resetn = 1'b1;

        // Main table: combinational build checked same cycle, registered
        // build checked after the edge, plus its one-cycle lag beforehand.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            apply(i);
            #1;
            check_comb(i);
            if (i > 0) check_reg(i - 1);
            @(posedge clk);
            #1;
            check_reg(i);
        end

        // Reset in mid-stream, then recovery on the first edge after release
        @(negedge clk);
        apply(0);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check_reg_zero("midreset");
        check_comb(0);
        @(negedge clk);
        resetn = 1'b1;
        apply(6);
        #1;
        check_reg_zero("midreset.hold");
        @(posedge clk);
        #1;
        check_reg(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
